// File: rtl/geofence_arbiter.sv
// Round-robin arbiter that streams 7-point frames from two requesters into one geofence engine.
// Build option: define GEOFENCE_TIMEOUT_EN to add the err output and a 64-cycle WAIT timeout.
module geofence_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [9:0] pt0_X,
    input  logic [9:0] pt0_Y,
    input  logic [9:0] pt1_X,
    input  logic [9:0] pt1_Y,
    output logic       gnt0,
    output logic       gnt1,
    output logic       pt_ack,
    output logic       done0,
    output logic       done1,
    output logic       result,
    output logic       eng_reset,
    output logic [9:0] eng_X,
    output logic [9:0] eng_Y,
    input  logic       eng_valid,
`ifdef GEOFENCE_TIMEOUT_EN
    output logic       err,
`endif
    input  logic       eng_is_inside
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_PT = 3'd6;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] gnt_q;
    logic [1:0] gnt_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       rr_last_q;
    logic       rr_last_d;
    logic       result_q;
    logic       result_d;
    logic [1:0] pick;

`ifdef GEOFENCE_TIMEOUT_EN
    logic [5:0] tmo_q;
    logic [5:0] tmo_d;
    logic       err_q;
    logic       err_d;
`endif

    // When both request, the one not served last wins.
    always_comb begin
        pick = 2'b00;
        if (req0 && req1) begin
            pick = rr_last_q ? 2'b01 : 2'b10;
        end else if (req0) begin
            pick = 2'b01;
        end else if (req1) begin
            pick = 2'b10;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        result_d  = result_q;
`ifdef GEOFENCE_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                gnt_d = 2'b00;
                if (req0 || req1) begin
                    gnt_d   = pick;
                    state_d = S_RST;
                end
            end
            S_RST: begin
                cnt_d   = 3'd0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (cnt_q == LAST_PT) begin
                    cnt_d   = 3'd0;
                    state_d = S_WAIT;
`ifdef GEOFENCE_TIMEOUT_EN
                    tmo_d   = 6'd0;
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (eng_valid) begin
                    result_d = eng_is_inside;
                    state_d  = S_DONE;
`ifdef GEOFENCE_TIMEOUT_EN
                    err_d    = 1'b0;
                end else if (tmo_q == 6'd63) begin
                    // Engine never answered: report outside with an error flag.
                    result_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmo_d = tmo_q + 6'd1;
`endif
                end
            end
            S_DONE: begin
                rr_last_d = gnt_q[1];
                gnt_d     = 2'b00;
                state_d   = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= 2'b00;
            cnt_q     <= 3'd0;
            rr_last_q <= 1'b1;
            result_q  <= 1'b0;
`ifdef GEOFENCE_TIMEOUT_EN
            tmo_q     <= 6'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            result_q  <= result_d;
`ifdef GEOFENCE_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    // Outputs are forced to their reset values for as long as reset is high.
    always_comb begin
        gnt0      = ~reset & gnt_q[0];
        gnt1      = ~reset & gnt_q[1];
        pt_ack    = ~reset & (state_q == S_LOAD);
        done0     = ~reset & (state_q == S_DONE) & gnt_q[0];
        done1     = ~reset & (state_q == S_DONE) & gnt_q[1];
        result    = ~reset & result_q;
        eng_reset = reset | (state_q == S_RST);
        eng_X     = 10'd0;
        eng_Y     = 10'd0;
        if (pt_ack) begin
            eng_X = gnt_q[1] ? pt1_X : pt0_X;
            eng_Y = gnt_q[1] ? pt1_Y : pt0_Y;
        end
`ifdef GEOFENCE_TIMEOUT_EN
        err       = ~reset & err_q;
`endif
    end

endmodule

// File: tb/tb_geofence_arbiter.sv
// Scoreboard bench for geofence_arbiter: model predicts frame order and results,
// a monitor checks every cycle and every done pulse against the queue.
module tb_geofence_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req0, req1;
    logic [9:0] pt0_X, pt0_Y, pt1_X, pt1_Y;
    logic       gnt0, gnt1, pt_ack, done0, done1, result;
    logic       eng_reset;
    logic [9:0] eng_X, eng_Y;
    logic       eng_valid, eng_is_inside;
`ifdef GEOFENCE_TIMEOUT_EN
    logic       err;
`endif

    geofence_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .pt0_X(pt0_X), .pt0_Y(pt0_Y), .pt1_X(pt1_X), .pt1_Y(pt1_Y),
        .gnt0(gnt0), .gnt1(gnt1), .pt_ack(pt_ack),
        .done0(done0), .done1(done1), .result(result),
        .eng_reset(eng_reset), .eng_X(eng_X), .eng_Y(eng_Y),
        .eng_valid(eng_valid),
`ifdef GEOFENCE_TIMEOUT_EN
        .err(err),
`endif
        .eng_is_inside(eng_is_inside)
    );

    localparam int NP = 7 * 48;

    logic [9:0] px [2][NP];
    logic [9:0] py [2][NP];
    int idx0 = 0;
    int idx1 = 0;

    assign pt0_X = px[0][idx0];
    assign pt0_Y = py[0][idx0];
    assign pt1_X = px[1][idx1];
    assign pt1_Y = py[1][idx1];

    typedef struct {
        int rq;
        int base;
        bit res;
        bit err;
        bit abort;
    } exp_t;

    exp_t q[$];
    int   vec = 0;
    int   miss = 0;
    int   rr_m = 1;
    int   nb[2];
    bit   long_dly = 1'b0;

    bit eng_v_e = 1'b0, eng_i_e = 1'b0;
    bit stray = 1'b0, stray_i = 1'b0;
    assign eng_valid     = eng_v_e | stray;
    assign eng_is_inside = eng_v_e ? eng_i_e : stray_i;

    function automatic bit fence_s(input int sx, input int sy);
        return ((sx + 2 * sy) % 5) < 2;
    endfunction

    function automatic bit fence_m(input int r, input int b);
        int sx = 0;
        int sy = 0;
        for (int k = 0; k < 7; k++) begin
            sx += int'(px[r][b+k]);
            sy += int'(py[r][b+k]);
        end
        return fence_s(sx, sy);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit a, input bit b);
        if (a && b) return (rr_m == 1) ? 0 : 1;
        return a ? 0 : 1;
    endfunction

    task automatic issue(input int r, input bit abort, input bit tmo);
        exp_t e;
        e.rq    = r;
        e.base  = nb[r];
        nb[r]  += 7;
        e.res   = tmo ? 1'b0 : fence_m(r, e.base);
        e.err   = tmo;
        e.abort = abort;
        if (!abort) rr_m = r;
        q.push_back(e);
    endtask

    // Reference engine: sums the 7 points after eng_reset, answers after a delay.
    initial begin
        int ec = 0;
        bit act = 1'b0;
        int ew = -1;
        int sx = 0;
        int sy = 0;
        forever begin
            @(negedge clk);
            eng_v_e = 1'b0;
            if (eng_reset) begin
                act = 1'b1; ec = 0; sx = 0; sy = 0; ew = -1;
            end else if (act && ec < 7) begin
                sx += int'(eng_X);
                sy += int'(eng_Y);
                ec++;
                if (ec == 7) ew = long_dly ? 80 : int'($urandom_range(0, 6));
            end else if (act && ew == 0) begin
                eng_v_e = 1'b1;
                eng_i_e = fence_s(sx, sy);
                act = 1'b0;
            end else if (act && ew > 0) begin
                ew--;
            end
        end
    end

    // Stray eng_valid while idle or loading; must be ignored.
    initial begin
        forever begin
            @(negedge clk);
            stray = 1'b0;
            if (!reset && (pt_ack || !(gnt0 || gnt1)) && $urandom_range(0, 3) == 0) begin
                stray   = 1'b1;
                stray_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Requesters step to their next point after each acknowledged cycle.
    initial begin
        bit a0, a1;
        forever begin
            @(negedge clk);
            a0 = pt_ack & gnt0;
            a1 = pt_ack & gnt1;
            @(posedge clk);
            #1;
            if (a0 && idx0 < NP - 1) idx0++;
            if (a1 && idx1 < NP - 1) idx1++;
        end
    end

    // Monitor
    initial begin
        exp_t e;
        int ackc = 0;
        int rstc = 0;
        bit last_res = 1'b0;
        bit last_err = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_gnt", int'({gnt1, gnt0}), 0);
                chk("rst_pt_ack", int'(pt_ack), 0);
                chk("rst_done", int'({done1, done0}), 0);
                chk("rst_result", int'(result), 0);
                chk("rst_eng_reset", int'(eng_reset), 1);
                chk("rst_eng_xy", int'({eng_X, eng_Y}), 0);
`ifdef GEOFENCE_TIMEOUT_EN
                chk("rst_err", int'(err), 0);
`endif
                while (q.size() > 0 && q[0].abort) void'(q.pop_front());
                ackc = 0; rstc = 0; last_res = 1'b0; last_err = 1'b0;
            end else begin
                chk("gnt_onehot", int'(gnt0 & gnt1), 0);
                if (eng_reset) begin
                    rstc++;
                    ackc = 0;
                end
                if (pt_ack) begin
                    if (q.size() == 0) begin
                        chk("ack_unexpected", int'(pt_ack), 0);
                    end else begin
                        e = q[0];
                        chk("ack_gnt", int'({gnt1, gnt0}), 1 << e.rq);
                        if (e.base + ackc < NP) begin
                            chk("eng_X", int'(eng_X), int'(px[e.rq][e.base+ackc]));
                            chk("eng_Y", int'(eng_Y), int'(py[e.rq][e.base+ackc]));
                        end
                    end
                    ackc++;
                end else begin
                    chk("eng_xy_idle", int'({eng_X, eng_Y}), 0);
                end
                if (done0 || done1) begin
                    if (q.size() == 0) begin
                        chk("done_unexpected", int'({done1, done0}), 0);
                    end else begin
                        e = q.pop_front();
                        chk("done_who", int'({done1, done0}), 1 << e.rq);
                        chk("done_gnt", int'({gnt1, gnt0}), 1 << e.rq);
                        chk("result", int'(result), int'(e.res));
                        chk("ack_count", ackc, 7);
                        chk("eng_reset_count", rstc, 1);
`ifdef GEOFENCE_TIMEOUT_EN
                        chk("err", int'(err), int'(e.err));
                        last_err = e.err;
`endif
                        last_res = e.res;
                    end
                    ackc = 0;
                    rstc = 0;
                end else begin
                    chk("result_hold", int'(result), int'(last_res));
`ifdef GEOFENCE_TIMEOUT_EN
                    chk("err_hold", int'(err), int'(last_err));
`endif
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(input int r, input int budget);
        int t = 0;
        while (((r == 0) ? gnt0 : gnt1) == 1'b0 && t < budget) begin
            tick(1);
            t++;
        end
        if (t >= budget) chk("gnt_timeout", int'((r == 0) ? gnt0 : gnt1), 1);
    endtask

    task automatic wait_free();
        int t = 0;
        while ((gnt0 || gnt1) && t < 300) begin
            tick(1);
            t++;
        end
        if (t >= 300) chk("free_timeout", int'(gnt0 | gnt1), 0);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 400) begin
            tick(1);
            t++;
        end
        if (t >= 400) chk("drain_timeout", q.size(), 0);
        wait_free();
    endtask

    task automatic drop(input int r);
        if (r == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic frame(input bit a, input bit b);
        int first;
        int second;
        bit tmo = 1'b0;
`ifdef GEOFENCE_TIMEOUT_EN
        tmo = long_dly;
`endif
        first = pick(a, b);
        issue(first, 1'b0, tmo);
        second = 1 - first;
        if (a && b) issue(second, 1'b0, tmo);
        req0 = a;
        req1 = b;
        wait_gnt(first, 80);
        tick(int'($urandom_range(0, 6)));
        drop(first);
        if (a && b) begin
            wait_gnt(second, 300);
            tick(int'($urandom_range(0, 6)));
            drop(second);
        end
        drain();
    endtask

    initial begin
        int ord[4];
        int pat;
        int d0x[7] = '{0, 10, 10, 0, 5, 2, 8};
        int d0y[7] = '{0, 0, 10, 10, 20, 2, 3};
        nb[0] = 0;
        nb[1] = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NP; k++) begin
                px[r][k] = 10'($urandom_range(0, 1023));
                py[r][k] = 10'($urandom_range(0, 1023));
            end
        end
        for (int k = 0; k < 7; k++) begin
            px[0][k] = 10'(d0x[k]);
            py[0][k] = 10'(d0y[k]);
        end

        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);

        frame(1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ord[i] = pick(1'b1, 1'b1);
            issue(ord[i], 1'b0, 1'b0);
        end
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(ord[i], 300);
            if (i == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end else begin
                wait_free();
            end
        end
        drain();

        frame(1'b0, 1'b1);

        issue(0, 1'b1, 1'b0);
        long_dly = 1'b1;
        req0 = 1'b1;
        wait_gnt(0, 80);
        req0 = 1'b0;
        tick(18);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rr_m = 1;
        long_dly = 1'b0;
        tick(3);
        chk("abort_cleared", q.size(), 0);
        frame(1'b1, 1'b0);

        long_dly = 1'b1;
        frame(1'b1, 1'b0);
        long_dly = 1'b0;

        for (int i = 0; i < 20; i++) begin
            pat = int'($urandom_range(1, 3));
            frame(pat[0], pat[1]);
        end

        tick(5);
        chk("final_queue", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/geofence_arbiter.md
GEOFENCE_ARBITER -- requirements
Module: geofence_arbiter

Interface
REQ-001 The block SHALL have the ports clk, in, 1, system clock; all logic on the rising edge.
REQ-002 The block SHALL have the port reset, in, 1, synchronous, active-high reset.
REQ-003 The block SHALL have the ports req0 / req1, in, 1 each, requester n requests one geofence evaluation.
REQ-004 The block SHALL have the ports pt0_X, pt0_Y, pt1_X, pt1_Y, in, 10 each, current point of requester n.
REQ-005 The block SHALL have the ports gnt0 / gnt1, out, 1 each, requester n owns the engine; one-hot or zero.
REQ-006 The block SHALL have the port pt_ack, out, 1, point accepted this cycle; the granted requester advances to its next point.
REQ-007 The block SHALL have the ports done0 / done1, out, 1 each, 1-cycle pulse, evaluation for requester n complete.
REQ-008 The block SHALL have the port result, out, 1, is_inside of the last completed evaluation.
REQ-009 The block SHALL have the ports eng_reset, out, 1; eng_X / eng_Y, out, 10 each; eng_valid, in, 1; eng_is_inside, in, 1: the geofence engine port.

Function
REQ-010 States SHALL be IDLE, RST, LOAD, WAIT, DONE; encoding is free.
REQ-011 IDLE: if req0 or req1 is high, the block SHALL register a one-hot grant and go to RST; otherwise it SHALL stay in IDLE.
REQ-012 Arbitration SHALL be round-robin: rr_last records the last served requester, and when both requesters are high the other one wins; rr_last resets to 1, so requester 0 wins first.
REQ-013 gnt0 / gnt1 SHALL be high from RST through DONE inclusive, and low in IDLE.
REQ-014 RST: eng_reset SHALL be 1 for exactly one cycle, then the block SHALL go to LOAD.
REQ-015 LOAD: for exactly 7 cycles the block SHALL hold pt_ack=1 and drive eng_X/eng_Y combinationally from the granted requester's pt_X/pt_Y.
REQ-016 LOAD: a 3-bit counter SHALL count 0..6, and point k SHALL be presented in LOAD cycle k; after count 6 the block SHALL go to WAIT.
REQ-017 Outside LOAD, eng_X and eng_Y SHALL be 0 and pt_ack SHALL be 0.
REQ-018 WAIT: on the first cycle with eng_valid=1, the block SHALL register eng_is_inside into result and go to DONE.
REQ-019 DONE: done_n SHALL pulse for the granted requester, rr_last SHALL update to that requester, and the next state SHALL be IDLE.
REQ-020 result SHALL hold its value until the next DONE.
REQ-021 Deassertion of req after grant SHALL be ignored; the frame SHALL complete normally.
REQ-022 eng_valid outside WAIT SHALL be ignored.
REQ-023 A requester still high in the cycle after DONE SHALL be eligible immediately, subject to round-robin.
REQ-024 Back-to-back frames SHALL have minimum spacing 1 IDLE cycle.

Reset
REQ-025 While reset=1 the block SHALL force state IDLE.
REQ-026 While reset=1 the block SHALL force gnt0=gnt1=0, pt_ack=0 and done0=done1=0.
REQ-027 While reset=1 the block SHALL force result=0, eng_reset=1, eng_X=eng_Y=0, counters=0 and rr_last=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first post-reset grant SHALL go through RST again.

Configuration
REQ-029 With macro GEOFENCE_TIMEOUT_EN defined, the block SHALL add output err (1 bit) and a 6-bit WAIT-cycle counter.
REQ-030 With GEOFENCE_TIMEOUT_EN defined, if 64 WAIT cycles pass without eng_valid, the block SHALL go to DONE with result=0 and err=1; err SHALL be 0 on a normal DONE and SHALL hold until the next DONE.
REQ-031 Without GEOFENCE_TIMEOUT_EN, the err port and counter SHALL be absent and WAIT SHALL wait indefinitely.

Verification
REQ-032 Scenario: req0 only, points (0,0),(10,0),(10,10),(0,10),(5,20),(2,2),(8,3) with a reference engine -> eng_reset at cycle 1, pt_ack cycles 2-8, done0 pulse, result matches engine.
REQ-033 Scenario: req0 and req1 both high continuously -> grants alternate 0,1,0,1; done0 and done1 each occur in exactly one frame.
REQ-034 Scenario: req1 dropped during LOAD cycle 3 -> all 7 points are still loaded and done1 still pulses.
REQ-035 Scenario: reset during WAIT -> no done pulse, gnt drops, and the next req0 goes IDLE->RST->LOAD again.
REQ-036 Scenario: stray eng_valid in IDLE or LOAD -> no state change and result unchanged.
REQ-037 Scenario (GEOFENCE_TIMEOUT_EN): engine held with eng_valid=0 -> after 64 WAIT cycles, done0 pulses with err=1 and result=0.
